register_64: RTL and testbench

REGISTER_64 -- requirements
Module: register_64

---
 rtl/register_64.sv | 47 ++++
 tb/tb_register_64.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/register_64.sv
// WIDTH-bit load-enable register with asynchronous active-low clear.
// Each bit is a separate flop with its own load/hold select, replicated by a generate loop.

module register_64_bit (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic d,
  output logic q
);
  logic bit_d;
  logic bit_q;

  // write_en=1 takes the new input, otherwise recirculate the stored value
  always_comb begin
    bit_d = bit_q;
    if (load) bit_d = d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bit_q <= 1'b0;
    else        bit_q <= bit_d;
  end

  assign q = bit_q;
endmodule

module register_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_en,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] DataOut
);
  // One shared enable feeds every bit, so all bits load on the same edge
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    register_64_bit u_bit (
      .clk   (clk),
      .reset (reset),
      .load  (write_en),
      .d     (DataIn[i]),
      .q     (DataOut[i])
    );
  end
endmodule

// File: tb/tb_register_64.sv
// Directed bench for register_64: stimulus pushes expected DataOut values into a
// queue and raises a sample event; a monitor pops and compares against DataOut.

module tb_register_64;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         write_en;
  logic [W-1:0] DataIn;
  logic [W-1:0] DataOut;

  typedef struct {
    string        name;
    logic [W-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   passed = 0;
  int   total  = 0;

  register_64 #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .write_en (write_en),
    .DataIn   (DataIn),
    .DataOut  (DataOut)
  );

  always #5 clk = ~clk;

  // Monitor: each sample event consumes one expected entry
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL monitor: sample with empty expectation queue, DataOut=%h", DataOut);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (DataOut !== e.val)
          $display("FAIL %s: DataOut=%h expected %h", e.name, DataOut, e.val);
        else
          passed++;
      end
    end
  end

  task automatic expect_out(input string name, input logic [W-1:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  // Advance to the next falling edge, then settle one unit before sampling
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    write_en = 1'b0;
    DataIn   = '0;
    #1;

    // Scenario 1: reset held with load active and all-ones data
    reset    = 1'b0;
    write_en = 1'b1;
    DataIn   = {W{1'b1}};
    #1;
    expect_out("reset_state", '0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("reset_hold_edge", '0);
    end

    // Scenario 2: release and load; nothing visible before the edge
    @(negedge clk);
    reset    = 1'b1;
    write_en = 1'b1;
    DataIn   = 64'h00000000F3473245;
    #1;
    expect_out("load_before_edge", '0);
    step();
    expect_out("load_first", 64'h00000000F3473245);

    // Scenario 3: hold for three edges while DataIn changes
    write_en = 1'b0;
    DataIn   = 64'h0000000021391832;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("hold", 64'h00000000F3473245);
    end

    // Scenario 4: back-to-back loads track one cycle late
    write_en = 1'b1;
    DataIn   = 64'h0000000032483294;
    step();
    expect_out("track_1", 64'h0000000032483294);
    DataIn   = 64'hA5A5A5A5A5A5A5A5;
    step();
    expect_out("track_2", 64'hA5A5A5A5A5A5A5A5);
    DataIn   = 64'h8000000000000001;
    step();
    expect_out("track_msb_lsb", 64'h8000000000000001);
    DataIn   = 64'hA5A5A5A5A5A5A5A5;
    step();
    expect_out("track_3", 64'hA5A5A5A5A5A5A5A5);

    // Scenario 5: asynchronous clear with clk low, then release with load off
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    expect_out("async_clear", '0);
    DataIn = 64'hDEADBEEFCAFEF00D;
    step();
    expect_out("reset_priority", '0);
    @(negedge clk);
    reset    = 1'b1;
    write_en = 1'b0;
    #1;
    step();
    expect_out("post_reset_hold", '0);
    write_en = 1'b1;
    DataIn   = 64'h0123456789ABCDEF;
    step();
    expect_out("post_reset_load", 64'h0123456789ABCDEF);

    // Scenario 6: enable pulsed only between edges has no effect
    write_en = 1'b0;
    @(negedge clk);
    #1;
    write_en = 1'b1;
    DataIn   = 64'h1;
    #2;
    write_en = 1'b0;
    step();
    expect_out("glitch_en", 64'h0123456789ABCDEF);

    // Bounded drain of any outstanding expectations
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
